// File: rtl/stream_demux_1to2.sv
// ============================================================================
// stream_demux_1to2
//
// Registered 1-to-2 stream demultiplexer. One valid/ready input stream is
// routed to output A (in_sel=0) or output B (in_sel=1). Each output has its
// own 2-entry FIFO, so a stalled consumer on one side never blocks words
// going to the other side.
//
// Ports
//   Clk       in   1      clock, rising edge
//   Reset     in   1      asynchronous, active-high reset
//   in_valid  in   1      input word present
//   in_ready  out  1      block accepts a word for the selected destination
//   in_data   in   WIDTH  input word
//   in_sel    in   1      destination: 0 -> A, 1 -> B (qualified by in_valid)
//   a_valid   out  1      output A holds a word
//   a_ready   in   1      consumer A takes the word
//   a_data    out  WIDTH  head of FIFO A (0 while empty)
//   b_valid   out  1      output B holds a word
//   b_ready   in   1      consumer B takes the word
//   b_data    out  WIDTH  head of FIFO B (0 while empty)
//
// Word accepted at edge N is visible on its output in cycle N+1; there is no
// combinational path from input data/valid to any output.
// ============================================================================

// ----------------------------------------------------------------------------
// stream_demux_fifo2
//
// Two-entry FIFO with an explicit EMPTY / ONE / FULL state machine. The
// entries are a head register (drives dout) and a tail register (second word).
//
// Ports
//   Clk    in   1      clock
//   Reset  in   1      asynchronous, active-high reset
//   push   in   1      write din (caller guarantees not FULL)
//   pop    in   1      consume head (ignored while EMPTY)
//   din    in   WIDTH  word to write
//   valid  out  1      FIFO holds at least one word
//   full   out  1      FIFO holds two words
//   dout   out  WIDTH  head word, 0 while EMPTY
// ----------------------------------------------------------------------------
module stream_demux_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t      state, state_nxt;
    logic [WIDTH-1:0] head, head_nxt;
    logic [WIDTH-1:0] tail, tail_nxt;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_nxt  = din;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Old head leaves, new word takes its place.
                    head_nxt = din;
                end else if (push) begin
                    state_nxt = FULL;
                    tail_nxt  = din;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // No push can arrive here: in_ready is low for this side.
                if (pop) begin
                    state_nxt = ONE;
                    head_nxt  = tail;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the two data registers are reset too; they are only two words, and
    // it keeps the outputs free of X straight after reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    assign valid = (state != EMPTY);
    assign full  = (state == FULL);
    // A stale head after the last pop must not leak out, so gate it.
    assign dout  = valid ? head : '0;

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module stream_demux_1to2 #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
);

    logic a_full, b_full;
    logic accept;
    logic push_a, push_b;
    logic pop_a, pop_b;

    // Ready depends only on the selected side's fullness; deliberately not on
    // in_valid or on either consumer's ready, so no combinational loop can
    // form through the producer or the consumers.
    assign in_ready = in_sel ? ~b_full : ~a_full;

    assign accept = in_valid & in_ready;
    assign push_a = accept & ~in_sel;
    assign push_b = accept &  in_sel;
    assign pop_a  = a_valid & a_ready;
    assign pop_b  = b_valid & b_ready;

    stream_demux_fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push_a),
        .pop   (pop_a),
        .din   (in_data),
        .valid (a_valid),
        .full  (a_full),
        .dout  (a_data)
    );

    stream_demux_fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push_b),
        .pop   (pop_b),
        .din   (in_data),
        .valid (b_valid),
        .full  (b_full),
        .dout  (b_data)
    );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Testbench for stream_demux_1to2: table-driven directed vectors, hand-written
// reset corner cases, then randomized traffic against a queue-based model.
module tb_stream_demux_1to2;

    localparam int WIDTH = 32;

    logic             Clk;
    logic             Reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;

    int n_cmp = 0;
    int n_err = 0;

    stream_demux_1to2 #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic sel, input logic [31:0] d,
                         input logic ar, input logic br);
        in_valid = iv;
        in_sel   = sel;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    // One directed vector: inputs for a cycle and the outputs expected during
    // that cycle (before the edge that applies the inputs).
    typedef struct {
        logic        iv;
        logic        sel;
        logic [31:0] d;
        logic        ar;
        logic        br;
        logic        e_av;
        logic [31:0] e_ad;
        logic        e_bv;
        logic [31:0] e_bd;
        logic        e_rdy;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic sel, input logic [31:0] d,
                                input logic ar, input logic br,
                                input logic e_av, input logic [31:0] e_ad,
                                input logic e_bv, input logic [31:0] e_bd,
                                input logic e_rdy);
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d; v.ar = ar; v.br = br;
        v.e_av = e_av; v.e_ad = e_ad; v.e_bv = e_bv; v.e_bd = e_bd; v.e_rdy = e_rdy;
        return v;
    endfunction

    vec_t tbl[16];

    // Reference model: each output is a bounded queue of at most two words.
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    initial begin
        // -------- Vector table (starts from empty FIFOs) --------
        // Two words to different sides, both consumers ready.
        tbl[0]  = mk(1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1);
        tbl[1]  = mk(1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0,        1'b1);
        tbl[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22222222, 1'b1);
        // A stalled: fill it, then B traffic still flows.
        tbl[3]  = mk(1'b1, 1'b0, 32'hA0,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1);
        tbl[4]  = mk(1'b1, 1'b0, 32'hA1,       1'b0, 1'b1, 1'b1, 32'hA0,       1'b0, 32'h0,        1'b1);
        tbl[5]  = mk(1'b1, 1'b0, 32'hFF,       1'b0, 1'b1, 1'b1, 32'hA0,       1'b0, 32'h0,        1'b0);
        tbl[6]  = mk(1'b1, 1'b1, 32'hB0,       1'b0, 1'b1, 1'b1, 32'hA0,       1'b0, 32'h0,        1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA0,       1'b1, 32'hB0,       1'b1);
        // Drain full A on consecutive cycles.
        tbl[8]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA0,       1'b0, 32'h0,        1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA1,       1'b0, 32'h0,        1'b1);
        tbl[10] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1);
        // Push and pop together while A holds one word.
        tbl[11] = mk(1'b1, 1'b0, 32'hC0,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1);
        tbl[12] = mk(1'b1, 1'b0, 32'hC1,       1'b1, 1'b1, 1'b1, 32'hC0,       1'b0, 32'h0,        1'b1);
        tbl[13] = mk(1'b0, 1'b1, 32'hDEAD,     1'b0, 1'b1, 1'b1, 32'hC1,       1'b0, 32'h0,        1'b1);
        tbl[14] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC1,       1'b0, 32'h0,        1'b1);
        tbl[15] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1);

        // -------- Reset while a word is offered --------
        Reset = 1'b1;
        drive(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_a_valid", {31'b0, a_valid}, 32'h0);
        check("rst_b_valid", {31'b0, b_valid}, 32'h0);
        check("rst_a_data", a_data, 32'h0);
        check("rst_b_data", b_data, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        Reset = 1'b0;
        #1;
        check("rel_in_ready_sel0", {31'b0, in_ready}, 32'h1);
        in_sel = 1'b1;
        #1;
        check("rel_in_ready_sel1", {31'b0, in_ready}, 32'h1);

        // -------- Table vectors --------
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].ar, tbl[i].br);
            #1;
            check($sformatf("v%0d_a_valid", i), {31'b0, a_valid}, {31'b0, tbl[i].e_av});
            check($sformatf("v%0d_a_data", i), a_data, tbl[i].e_ad);
            check($sformatf("v%0d_b_valid", i), {31'b0, b_valid}, {31'b0, tbl[i].e_bv});
            check($sformatf("v%0d_b_data", i), b_data, tbl[i].e_bd);
            check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].e_rdy});
        end

        // -------- Async reset with A FULL and B ONE --------
        @(negedge Clk); drive(1'b1, 1'b0, 32'hE0, 1'b0, 1'b0);
        @(negedge Clk); drive(1'b1, 1'b0, 32'hE1, 1'b0, 1'b0);
        @(negedge Clk); drive(1'b1, 1'b1, 32'hF0, 1'b0, 1'b0);
        @(negedge Clk); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("pre_rst_a_full", {31'b0, in_ready}, 32'h0);
        check("pre_rst_b_data", b_data, 32'hF0);
        Reset = 1'b1;
        #1;
        check("async_rst_a_valid", {31'b0, a_valid}, 32'h0);
        check("async_rst_b_valid", {31'b0, b_valid}, 32'h0);
        check("async_rst_a_data", a_data, 32'h0);
        check("async_rst_b_data", b_data, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            #1;
            check("post_rst_a_valid", {31'b0, a_valid}, 32'h0);
            check("post_rst_b_valid", {31'b0, b_valid}, 32'h0);
            check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
        end

        // -------- Randomized traffic against the queue model --------
        qa.delete();
        qb.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        exp_rdy;
            logic [31:0] exp_ad, exp_bd;
            @(negedge Clk);
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
            #1;
            exp_rdy = in_sel ? (qb.size() < 2) : (qa.size() < 2);
            exp_ad  = (qa.size() > 0) ? qa[0] : 32'h0;
            exp_bd  = (qb.size() > 0) ? qb[0] : 32'h0;
            check("rnd_a_valid", {31'b0, a_valid}, {31'b0, (qa.size() > 0)});
            check("rnd_b_valid", {31'b0, b_valid}, {31'b0, (qb.size() > 0)});
            check("rnd_a_data", a_data, exp_ad);
            check("rnd_b_data", b_data, exp_bd);
            check("rnd_in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            // Model the coming edge: consumers take heads, then the new word
            // joins the tail of its destination queue.
            if (a_ready && qa.size() > 0) void'(qa.pop_front());
            if (b_ready && qb.size() > 0) void'(qb.pop_front());
            if (in_valid && exp_rdy) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
